// File: rtl/ram_bus_master.sv
// Valid/ready bus initiator for the shared tri-state RAM bus: one response per request.
// Optional write read-back verification is compiled in with `define WRITE_VERIFY_EN.
module ram_bus_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_oe,
    inout  wire  [DATA_W-1:0] ram_data
);

`ifdef WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, VF_A, VF_D} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, RD_A, RD_D} state_t;
`endif

    state_t            state, next_state;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              next_we, next_oe;
    logic              rsp_done, capture;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign ram_data  = (state == WR) ? wdata_q : {DATA_W{1'bz}};

    // ram_we/ram_oe are registered, so they are derived from the state being entered
    always_comb begin
        next_state = state;
        rsp_done   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = req_we ? WR : RD_A;
            end
            WR: begin
`ifdef WRITE_VERIFY_EN
                next_state = VF_A;
`else
                next_state = IDLE;
                rsp_done   = 1'b1;
`endif
            end
            RD_A: next_state = RD_D;
            RD_D: begin
                next_state = IDLE;
                rsp_done   = 1'b1;
                capture    = 1'b1;
            end
`ifdef WRITE_VERIFY_EN
            VF_A: next_state = VF_D;
            VF_D: begin
                next_state = IDLE;
                rsp_done   = 1'b1;
                capture    = 1'b1;
            end
`endif
            default: next_state = IDLE;
        endcase
        next_we = (next_state == WR);
`ifdef WRITE_VERIFY_EN
        next_oe = (next_state == RD_D) || (next_state == VF_D);
`else
        next_oe = (next_state == RD_D);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= next_state;
            ram_we    <= next_we;
            ram_oe    <= next_oe;
            rsp_valid <= rsp_done;
            if (accept) begin
                ram_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (capture) rsp_rdata <= ram_data;
        end
    end

`ifdef WRITE_VERIFY_EN
    // Error flag holds between responses; it is only meaningful alongside rsp_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              rsp_err <= 1'b0;
        else if (state == VF_D) rsp_err <= (ram_data != wdata_q);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed self-checking bench for ram_bus_master with a registered-output RAM model.
// Define WRITE_VERIFY_EN to also exercise the read-back verify path.
module tb_ram_bus_master;

`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WR_LAT = VERIFY ? 4 : 2;
    localparam int RD_LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic       ram_oe;
    wire  [7:0] ram_data;

    int tests_run = 0;
    int tests_failed = 0;
    int safety_violations = 0;
    int rsp_seen = 0;
    int rsp_expected = 0;
    logic [7:0] last_rdata = 8'h00;

    // RAM model: writes on we, otherwise reloads its output buffer every edge
    logic [7:0] mem [256];
    logic [7:0] out_buf = 8'h00;
    logic       corrupt = 1'b0;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= corrupt ? ~ram_data : ram_data;
        else        out_buf       <= mem[ram_addr];
    end
    assign ram_data = (ram_oe && !ram_we) ? out_buf : 8'hzz;

    always @(negedge clk) begin
        if (ram_oe && ram_we) safety_violations++;
        if (rsp_valid) rsp_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the master idle; returns at the negedge of the response cycle
    // with req_valid still high, so the next call is accepted back-to-back.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] rd_expect, input string tag);
        int lat = 0;
        int we_cycles = 0;
        int oe_cycles = 0;
        int ready_busy = 0;
        int addr_errs = 0;
        int data_errs = 0;
        logic [7:0] exp_rdata;
        logic       exp_err;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            lat++;
            if (rsp_valid || lat > 8) break;
            if (ram_addr !== addr) addr_errs++;
            if (req_ready) ready_busy++;
            if (ram_we) begin
                we_cycles++;
                if (ram_data !== wdata) data_errs++;
            end
            if (ram_oe) oe_cycles++;
        end
        if (we) begin
            exp_rdata = VERIFY ? (corrupt ? ~wdata : wdata) : last_rdata;
            exp_err   = VERIFY && corrupt;
        end else begin
            exp_rdata = rd_expect;
            exp_err   = 1'b0;
        end
        rsp_expected++;
        last_rdata = exp_rdata;
        checkOutput({tag, "_latency"}, lat, we ? WR_LAT : RD_LAT);
        checkOutput({tag, "_we_cycles"}, we_cycles, we ? 1 : 0);
        checkOutput({tag, "_oe_cycles"}, oe_cycles, (we && !VERIFY) ? 0 : 1);
        checkOutput({tag, "_ready_busy"}, ready_busy, 0);
        checkOutput({tag, "_addr_stable"}, addr_errs, 0);
        checkOutput({tag, "_bus_wdata"}, data_errs, 0);
        checkOutput({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rdata});
        checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h5A;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_we", {31'd0, ram_we}, 32'd0);
        checkOutput("rst_oe", {31'd0, ram_oe}, 32'd0);
        checkOutput("rst_addr", {24'd0, ram_addr}, 32'd0);
        checkOutput("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b1, 8'h10, 8'hA5, 8'h00, "w10");
        applyStimulus(1'b0, 8'h10, 8'h00, 8'hA5, "r10");
        req_valid = 1'b0;
        @(negedge clk);

        applyStimulus(1'b1, 8'hFF, 8'h3C, 8'h00, "wFF");
        applyStimulus(1'b0, 8'hFF, 8'h00, 8'h3C, "rFF");
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h5A, "r00");
        req_valid = 1'b0;
        @(negedge clk);

        applyStimulus(1'b1, 8'h33, 8'h11, 8'h00, "alt_w33");
        applyStimulus(1'b0, 8'h33, 8'h00, 8'h11, "alt_r33");
        applyStimulus(1'b1, 8'h34, 8'h22, 8'h00, "alt_w34");
        applyStimulus(1'b0, 8'h34, 8'h00, 8'h22, "alt_r34");
        applyStimulus(1'b1, 8'h20, 8'h4B, 8'h00, "alt_w20");
        applyStimulus(1'b0, 8'h10, 8'h00, 8'hA5, "alt_r10");
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while the read of 0x20 is in RD_D
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rdd_oe_before_rst", {31'd0, ram_oe}, 32'd1);
        snap = rsp_seen;
        reset = 1'b1;
        #1;
        checkOutput("midrst_oe", {31'd0, ram_oe}, 32'd0);
        checkOutput("midrst_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("midrst_addr", {24'd0, ram_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_rdata = 8'h00;
        #1;
        checkOutput("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_rsp", rsp_seen - snap, 0);
        checkOutput("midrst_rdata", {24'd0, rsp_rdata}, 32'd0);
        applyStimulus(1'b0, 8'h20, 8'h00, 8'h4B, "r20_after_rst");
        req_valid = 1'b0;
        @(negedge clk);

`ifdef WRITE_VERIFY_EN
        applyStimulus(1'b1, 8'h05, 8'h77, 8'h00, "vf_w05");
        req_valid = 1'b0;
        @(negedge clk);
        corrupt = 1'b1;
        applyStimulus(1'b1, 8'h06, 8'h12, 8'h00, "vf_corrupt");
        req_valid = 1'b0;
        corrupt = 1'b0;
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        checkOutput("bus_safety", safety_violations, 0);
        checkOutput("rsp_count", rsp_seen, rsp_expected);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
